// File: rtl/ibex_wb_master_bridge.sv
// rtl/ibex_wb_master_bridge.sv - Ibex req/gnt/rvalid host port to Wishbone B4 pipelined master
module ibex_wb_master_bridge #(
   parameter int unsigned AddrWidth      = 32,
   parameter int unsigned DataWidth      = 32,
   parameter int unsigned MaxOutstanding = 4,
   parameter int unsigned TimeoutCycles  = 256
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   req_i,
   output logic                   gnt_o,
   input  logic [AddrWidth-1:0]   addr_i,
   input  logic                   we_i,
   input  logic [DataWidth/8-1:0] be_i,
   input  logic [DataWidth-1:0]   wdata_i,
   output logic                   rvalid_o,
   output logic [DataWidth-1:0]   rdata_o,
   output logic                   err_o,
   output logic                   wb_cyc_o,
   output logic                   wb_stb_o,
   output logic                   wb_we_o,
   output logic [AddrWidth-3:0]   wb_addr_o,
   output logic [DataWidth/8-1:0] wb_sel_o,
   output logic [DataWidth-1:0]   wb_data_o,
   input  logic                   wb_stall_i,
   input  logic                   wb_ack_i,
   input  logic                   wb_err_i,
   input  logic [DataWidth-1:0]   wb_data_i
);

   localparam int unsigned BeWidth    = DataWidth / 8;
   localparam int unsigned TimerWidth = (TimeoutCycles > 2) ? $clog2(TimeoutCycles) : 1;
   localparam logic [3:0]  MaxCnt     = 4'(MaxOutstanding);
   localparam logic [TimerWidth-1:0] TimerLast = TimerWidth'(TimeoutCycles - 1);

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StBusy  = 2'd1,
      StFlush = 2'd2
   } state_e;

   state_e                 state_q, state_d;
   logic [3:0]             cnt_q, cnt_d;
   logic [TimerWidth-1:0]  timer_q, timer_d;
   logic                   stb_q, stb_d;
   logic                   we_q, we_d;
   logic [AddrWidth-3:0]   addr_q, addr_d;
   logic [BeWidth-1:0]     sel_q, sel_d;
   logic [DataWidth-1:0]   wdata_q, wdata_d;
   logic                   rvalid_q, rvalid_d;
   logic                   rerr_q, rerr_d;
   logic [DataWidth-1:0]   rdata_q, rdata_d;
   // Write flag of each outstanding transfer, in issue order, so a write
   // response can return zero data. 16 slots cover the 15-transfer maximum.
   logic [15:0]            we_fifo_q, we_fifo_d;
   logic [3:0]             wr_ptr_q, wr_ptr_d;
   logic [3:0]             rd_ptr_q, rd_ptr_d;

   logic gnt;
   logic bus_resp;
   logic timeout;
   logic err_event;
   logic flush_resp;
   logic resp;
   logic unused_addr;

   assign unused_addr = ^addr_i[1:0];

   // Next-state, response and request-register logic for the whole bridge.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      timer_d   = timer_q;
      stb_d     = stb_q;
      we_d      = we_q;
      addr_d    = addr_q;
      sel_d     = sel_q;
      wdata_d   = wdata_q;
      we_fifo_d = we_fifo_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      rvalid_d  = 1'b0;
      rerr_d    = 1'b0;
      rdata_d   = '0;

      bus_resp   = (state_q == StBusy) && (cnt_q != 4'd0) && (wb_ack_i || wb_err_i);
      timeout    = (state_q == StBusy) && !(wb_ack_i || wb_err_i) && (timer_q == TimerLast);
      err_event  = ((state_q == StBusy) && wb_err_i) || timeout;
      flush_resp = (state_q == StFlush) && (cnt_q != 4'd0);
      resp       = bus_resp || timeout || flush_resp;

      // A cycle that starts a flush takes no new work; its request register is discarded.
      gnt = req_i && (state_q != StFlush) && !err_event
            && (!stb_q || !wb_stall_i) && (cnt_q < MaxCnt);

      cnt_d = cnt_q + {3'b000, gnt} - {3'b000, resp};

      if (gnt) begin
         we_fifo_d[wr_ptr_q] = we_i;
         wr_ptr_d            = wr_ptr_q + 4'd1;
      end
      if (resp) begin
         rd_ptr_d = rd_ptr_q + 4'd1;
      end

      rvalid_d = resp;
      rerr_d   = err_event || flush_resp;
      if (bus_resp && !wb_err_i && !we_fifo_q[rd_ptr_q]) begin
         rdata_d = wb_data_i;
      end

      if (err_event) begin
         stb_d = 1'b0;
      end else if (gnt) begin
         stb_d   = 1'b1;
         we_d    = we_i;
         addr_d  = addr_i[AddrWidth-1:2];
         sel_d   = be_i;
         wdata_d = wdata_i;
      end else if (stb_q && !wb_stall_i) begin
         stb_d = 1'b0;
      end

      unique case (state_q)
         StIdle: begin
            timer_d = '0;
            if (gnt) begin
               state_d = StBusy;
            end
         end
         StBusy: begin
            if (wb_ack_i || wb_err_i || timeout) begin
               timer_d = '0;
            end else begin
               timer_d = timer_q + TimerWidth'(1);
            end
            if (err_event) begin
               state_d = StFlush;
            end else if (cnt_d == 4'd0) begin
               state_d = StIdle;
            end
         end
         StFlush: begin
            timer_d = '0;
            if (cnt_q <= 4'd1) begin
               state_d = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
            timer_d = '0;
         end
      endcase
   end

   // State and datapath registers; reset abandons any transfer in flight.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= StIdle;
         cnt_q     <= 4'd0;
         timer_q   <= '0;
         stb_q     <= 1'b0;
         we_q      <= 1'b0;
         addr_q    <= '0;
         sel_q     <= '0;
         wdata_q   <= '0;
         rvalid_q  <= 1'b0;
         rerr_q    <= 1'b0;
         rdata_q   <= '0;
         we_fifo_q <= '0;
         wr_ptr_q  <= 4'd0;
         rd_ptr_q  <= 4'd0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         timer_q   <= timer_d;
         stb_q     <= stb_d;
         we_q      <= we_d;
         addr_q    <= addr_d;
         sel_q     <= sel_d;
         wdata_q   <= wdata_d;
         rvalid_q  <= rvalid_d;
         rerr_q    <= rerr_d;
         rdata_q   <= rdata_d;
         we_fifo_q <= we_fifo_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
      end
   end

   assign gnt_o     = gnt;
   assign rvalid_o  = rvalid_q;
   assign rdata_o   = rdata_q;
   assign err_o     = rerr_q;
   assign wb_cyc_o  = (cnt_q != 4'd0) && (state_q != StFlush);
   assign wb_stb_o  = stb_q;
   assign wb_we_o   = we_q;
   assign wb_addr_o = addr_q;
   assign wb_sel_o  = sel_q;
   assign wb_data_o = wdata_q;

endmodule

// File: tb/tb_ibex_wb_master_bridge.sv
// tb/tb_ibex_wb_master_bridge.sv - scoreboard bench for ibex_wb_master_bridge
module tb_ibex_wb_master_bridge;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req = 1'b0;
   logic        gnt;
   logic [31:0] addr = '0;
   logic        we = 1'b0;
   logic [3:0]  be = 4'hf;
   logic [31:0] wdata = '0;
   logic        rvalid;
   logic [31:0] rdata;
   logic        err;
   logic        wb_cyc, wb_stb, wb_we;
   logic [29:0] wb_addr;
   logic [3:0]  wb_sel;
   logic [31:0] wb_dout;
   logic        wb_stall = 1'b0;
   logic        wb_ack = 1'b0;
   logic        wb_err = 1'b0;
   logic [31:0] wb_din = '0;

   ibex_wb_master_bridge #(
      .AddrWidth(32), .DataWidth(32), .MaxOutstanding(4), .TimeoutCycles(16)
   ) dut (
      .clk_i(clk), .rst_i(rst), .req_i(req), .gnt_o(gnt), .addr_i(addr),
      .we_i(we), .be_i(be), .wdata_i(wdata), .rvalid_o(rvalid), .rdata_o(rdata),
      .err_o(err), .wb_cyc_o(wb_cyc), .wb_stb_o(wb_stb), .wb_we_o(wb_we),
      .wb_addr_o(wb_addr), .wb_sel_o(wb_sel), .wb_data_o(wb_dout),
      .wb_stall_i(wb_stall), .wb_ack_i(wb_ack), .wb_err_i(wb_err), .wb_data_i(wb_din)
   );

   always #5 clk = ~clk;

   int cyc_n = 0;
   always @(posedge clk) cyc_n <= cyc_n + 1;

   typedef struct {
      logic        err;
      logic [31:0] data;
      int          cyc;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   n_cmp = 0;
   int   n_bad = 0;
   int   ngnt;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
      n_cmp++;
      if (act !== expv) begin
         n_bad++;
         $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, expv, cyc_n);
      end
   endtask

   task automatic push(input logic e, input logic [31:0] d, input int c);
      exp_t x;
      x.err  = e;
      x.data = d;
      x.cyc  = c;
      exp_q.push_back(x);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard monitor: every rvalid must match the oldest expected response.
   initial begin
      forever begin
         @(negedge clk);
         if (!rst && rvalid === 1'b1) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_rvalid: got rvalid=1 required none (cycle %0d)", cyc_n);
            end else begin
               mon_e = exp_q.pop_front();
               chk("rsp_err", {63'd0, err}, {63'd0, mon_e.err});
               chk("rsp_data", {32'd0, rdata}, {32'd0, mon_e.data});
               if (mon_e.cyc >= 0) chk("rsp_cycle", 64'(cyc_n), 64'(mon_e.cyc));
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic run_read(input logic [31:0] a, input logic [31:0] d);
      req = 1'b1; addr = a; we = 1'b0; be = 4'hf;
      #1;
      chk("rd_gnt", {63'd0, gnt}, 64'd1);
      tick();
      req = 1'b0;
      chk("rd_stb", {63'd0, wb_stb}, 64'd1);
      chk("rd_wb_addr", {34'd0, wb_addr}, {34'd0, a[31:2]});
      chk("rd_wb_we", {63'd0, wb_we}, 64'd0);
      tick();
      tick();
      wb_ack = 1'b1; wb_din = d;
      push(1'b0, d, cyc_n + 1);
      tick();
      wb_ack = 1'b0; wb_din = '0;
      tick();
      tick();
      chk("rd_cyc_idle", {63'd0, wb_cyc}, 64'd0);
   endtask

   initial begin
      #1 rst = 1'b1;
      tick();
      tick();
      chk("reset_ctrl", {58'd0, wb_cyc, wb_stb, wb_we, rvalid, err, gnt}, 64'd0);
      chk("reset_data", {2'd0, wb_addr, rdata}, 64'd0);
      rst = 1'b0;
      tick();

      // Single read
      run_read(32'h0010_0000, 32'h0bad_beef);

      // Four back-to-back writes, acked one per cycle after one cycle of latency
      for (int i = 0; i < 6; i++) begin
         req = (i < 4); we = 1'b1; addr = 32'h200 + 32'(4 * i);
         wdata = 32'h1111_0000 + 32'(i);
         wb_ack = (i >= 2); wb_din = 32'hdead_beef;
         if (i >= 2) push(1'b0, 32'h0, cyc_n + 1);
         #1;
         if (i < 4) chk("wr_gnt", {63'd0, gnt}, 64'd1);
         if (i == 1) chk("wr_wb_data", {32'd0, wb_dout}, 64'h1111_0000);
         tick();
      end
      req = 1'b0; wb_ack = 1'b0; wb_din = '0;
      tick();
      tick();
      chk("wr_cyc_idle", {62'd0, wb_cyc, wb_stb}, 64'd0);

      // Six requests against a slave that withholds ack, then stalls
      ngnt = 0;
      for (int i = 0; i < 6; i++) begin
         req = 1'b1; we = 1'b0; addr = 32'h300 + 32'(4 * i);
         if (i == 4) wb_stall = 1'b1;
         #1;
         if (gnt) ngnt++;
         if (i >= 4) begin
            chk("max_out_gnt", {63'd0, gnt}, 64'd0);
            chk("stall_stb", {63'd0, wb_stb}, 64'd1);
            chk("stall_addr", {34'd0, wb_addr}, 64'h0c3);
         end
         tick();
      end
      req = 1'b0;
      chk("stall_addr_hold", {34'd0, wb_addr}, 64'h0c3);
      chk("gnt_count", 64'(ngnt), 64'd4);
      tick();
      for (int j = 0; j < 4; j++) begin
         wb_stall = 1'b0; wb_ack = 1'b1; wb_din = 32'ha0 + 32'(j);
         push(1'b0, 32'ha0 + 32'(j), cyc_n + 1);
         tick();
      end
      wb_ack = 1'b0; wb_din = '0;
      tick();
      tick();
      chk("stall_cyc_idle", {63'd0, wb_cyc}, 64'd0);

      // Three outstanding, error on the first response
      for (int i = 0; i < 3; i++) begin
         req = 1'b1; we = 1'b0; addr = 32'h400 + 32'(4 * i);
         #1;
         chk("err_gnt", {63'd0, gnt}, 64'd1);
         tick();
      end
      req = 1'b0; wb_err = 1'b1;
      push(1'b1, 32'h0, cyc_n + 1);
      push(1'b1, 32'h0, cyc_n + 2);
      push(1'b1, 32'h0, cyc_n + 3);
      tick();
      wb_err = 1'b0; wb_ack = 1'b1; wb_din = 32'h55;
      chk("err_cyc_stb_drop", {62'd0, wb_cyc, wb_stb}, 64'd0);
      tick();
      wb_ack = 1'b0; wb_din = '0;
      tick();
      tick();
      run_read(32'h0000_0500, 32'h1234_5678);

      // Timeout on a single read
      req = 1'b1; we = 1'b0; addr = 32'h600;
      #1;
      chk("to_gnt", {63'd0, gnt}, 64'd1);
      tick();
      req = 1'b0;
      chk("to_stb", {63'd0, wb_stb}, 64'd1);
      push(1'b1, 32'h0, cyc_n + 16);
      repeat (20) tick();
      chk("to_cyc_idle", {63'd0, wb_cyc}, 64'd0);

      // Reset with two outstanding
      for (int i = 0; i < 2; i++) begin
         req = 1'b1; we = 1'b1; addr = 32'h700 + 32'(4 * i); wdata = 32'hcafe_0000;
         tick();
      end
      req = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("async_rst_ctrl", {58'd0, wb_cyc, wb_stb, wb_we, rvalid, err, gnt}, 64'd0);
      chk("async_rst_addr", {34'd0, wb_addr}, 64'd0);
      chk("async_rst_data", {wb_dout, rdata}, 64'd0);
      tick();
      rst = 1'b0;
      repeat (5) tick();
      run_read(32'h0010_0000, 32'h0bad_beef);

      tick();
      chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
